board_controller: RTL and testbench

Player-input and game-state stage directly upstream of the VGA display unit. Conditions the five push-buttons, moves a cursor over the 8×8 board, and runs a select/move state machine. Owns the board register and drives the display unit's `BOARD`, `CURSOR_ADDR`, `SELECT_ADDR` and `SELECT_EN` inputs. No chess legality checks beyond turn ownership and own-piece capture prevention.

---
 rtl/board_controller_pkg.sv | 69 ++++++
 rtl/board_controller_button_conditioner.sv | 73 +++++++
 rtl/board_controller.sv | 233 +++++++++++++++++++++++
 tb/tb_board_controller.sv | 234 +++++++++++++++++++++++
 4 files changed

// File: rtl/board_controller_pkg.sv
// ---------------------------------------------------------------------------
// board_controller_pkg
// Shared chess definitions for the board controller and the display unit:
// piece codes, colour constants, select/move FSM encodings, back-rank piece
// order, push-button indices and the reset board image.
// ---------------------------------------------------------------------------
package board_controller_pkg;

  // Piece codes (low three bits of a square nibble)
  localparam logic [2:0] PIECE_NONE   = 3'd0;
  localparam logic [2:0] PIECE_PAWN   = 3'd1;
  localparam logic [2:0] PIECE_KNIGHT = 3'd2;
  localparam logic [2:0] PIECE_BISHOP = 3'd3;
  localparam logic [2:0] PIECE_ROOK   = 3'd4;
  localparam logic [2:0] PIECE_QUEEN  = 3'd5;
  localparam logic [2:0] PIECE_KING   = 3'd6;

  // Colour (bit 3 of a square nibble, also the TURN encoding)
  localparam logic COLOR_WHITE = 1'b0;
  localparam logic COLOR_BLACK = 1'b1;

  // Cursor starts on the white king square: row 7, col 4
  localparam logic [5:0] CURSOR_RESET = 6'd60;

  // Indices of the conditioned buttons inside the press vector
  localparam int BTN_IDX_UP     = 0;
  localparam int BTN_IDX_DOWN   = 1;
  localparam int BTN_IDX_LEFT   = 2;
  localparam int BTN_IDX_RIGHT  = 3;
  localparam int BTN_IDX_CENTER = 4;
  localparam int BTN_COUNT      = 5;

  typedef enum logic [1:0] {
    ST_IDLE     = 2'd0,
    ST_SELECTED = 2'd1,
    ST_COMMIT   = 2'd2
  } state_e;

  // Back-rank piece order, column 0 to 7: R N B Q K B N R
  function automatic logic [2:0] back_rank_piece(input logic [2:0] col);
    logic [2:0] piece;
    case (col)
      3'd0:    piece = PIECE_ROOK;
      3'd1:    piece = PIECE_KNIGHT;
      3'd2:    piece = PIECE_BISHOP;
      3'd3:    piece = PIECE_QUEEN;
      3'd4:    piece = PIECE_KING;
      3'd5:    piece = PIECE_BISHOP;
      3'd6:    piece = PIECE_KNIGHT;
      3'd7:    piece = PIECE_ROOK;
      default: piece = PIECE_NONE;
    endcase
    return piece;
  endfunction

  // Starting position; square a lives in bits [a*4+3 : a*4]
  function automatic logic [255:0] initial_board();
    logic [255:0] b;
    b = 256'd0;
    for (int c = 0; c < 8; c++) begin
      b[c*4 +: 4]        = {COLOR_BLACK, back_rank_piece(3'(c))};
      b[(8 + c)*4 +: 4]  = {COLOR_BLACK, PIECE_PAWN};
      b[(48 + c)*4 +: 4] = {COLOR_WHITE, PIECE_PAWN};
      b[(56 + c)*4 +: 4] = {COLOR_WHITE, back_rank_piece(3'(c))};
    end
    return b;
  endfunction

endpackage

// File: rtl/board_controller_button_conditioner.sv
// ---------------------------------------------------------------------------
// button_conditioner
// Conditions one raw push-button: 2-FF synchroniser, debounce counter and
// rising-edge detector.
//   clk    : system clock
//   rst_n  : asynchronous active-low reset (deassertion already synchronised)
//   btn    : raw asynchronous button, active-high
//   level  : debounced button level
//   press  : one-cycle registered pulse on each debounced rising edge
// Latency from a stable raw high to press: DEBOUNCE_CYCLES + 3 cycles.
// ---------------------------------------------------------------------------
module button_conditioner #(
  parameter int DEBOUNCE_CYCLES = 1_000_000
) (
  input  logic clk,
  input  logic rst_n,
  input  logic btn,
  output logic level,
  output logic press
);

  localparam int CW = (DEBOUNCE_CYCLES > 2) ? $clog2(DEBOUNCE_CYCLES) : 1;
  localparam logic [CW-1:0] CNT_LAST = CW'(DEBOUNCE_CYCLES - 1);

  logic          sync1_r;
  logic          sync2_r;
  logic          level_r;
  logic          level_d_r;
  logic          press_r;
  logic [CW-1:0] cnt_r;

  // Two-flop synchroniser for the asynchronous button input
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sync1_r <= 1'b0;
      sync2_r <= 1'b0;
    end else begin
      sync1_r <= btn;
      sync2_r <= sync1_r;
    end
  end

  // Debounce: the level flips on the DEBOUNCE_CYCLES-th consecutive
  // disagreeing cycle; any agreeing cycle restarts the count
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      level_r <= 1'b0;
      cnt_r   <= '0;
    end else if (sync2_r == level_r) begin
      cnt_r   <= '0;
    end else if (cnt_r == CNT_LAST) begin
      level_r <= ~level_r;
      cnt_r   <= '0;
    end else begin
      cnt_r   <= cnt_r + 1'b1;
    end
  end

  // Registered rising-edge detector; releases produce no pulse
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      level_d_r <= 1'b0;
      press_r   <= 1'b0;
    end else begin
      level_d_r <= level_r;
      press_r   <= level_r & ~level_d_r;
    end
  end

  assign level = level_r;
  assign press = press_r;

endmodule

// File: rtl/board_controller.sv
// ---------------------------------------------------------------------------
// board_controller
// Player-input and game-state stage feeding the VGA display unit.
//   clk          : system clock (shared with the display unit)
//   rst          : asynchronous active-low reset, deassertion synchronised here
//   BTN_*        : raw push-buttons, active-high
//   BOARD        : 64 squares x 4 bits {colour, piece}
//   CURSOR_ADDR  : {row, col} of the cursor, row 0 = black side
//   SELECT_ADDR  : selected square
//   SELECT_EN    : a selection is active
//   TURN         : side to move (0 white, 1 black)
//   MOVE_DONE    : one-cycle pulse after a move is committed
// ---------------------------------------------------------------------------
module board_controller
  import board_controller_pkg::*;
#(
  parameter int DEBOUNCE_CYCLES = 1_000_000
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         BTN_UP,
  input  logic         BTN_DOWN,
  input  logic         BTN_LEFT,
  input  logic         BTN_RIGHT,
  input  logic         BTN_CENTER,
  output logic [255:0] BOARD,
  output logic [5:0]   CURSOR_ADDR,
  output logic [5:0]   SELECT_ADDR,
  output logic         SELECT_EN,
  output logic         TURN,
  output logic         MOVE_DONE
);

  logic [1:0]           rst_sync_r;
  logic                 rst_n_s;
  logic [BTN_COUNT-1:0] raw_s;
  logic [BTN_COUNT-1:0] press_s;
  logic [BTN_COUNT-1:0] btn_level_unused_s;

  logic                 act_center_s;
  logic                 act_up_s;
  logic                 act_down_s;
  logic                 act_left_s;
  logic                 act_right_s;

  state_e               state_r;
  state_e               state_next_s;
  logic [2:0]           cursor_row_r;
  logic [2:0]           cursor_col_r;
  logic [5:0]           cursor_addr_s;
  logic [5:0]           select_addr_r;
  logic                 select_en_r;
  logic                 select_en_next_s;
  logic                 select_load_s;
  logic [5:0]           dest_r;
  logic                 dest_load_s;
  logic                 commit_s;
  logic                 turn_r;
  logic                 move_done_r;
  logic [255:0]         board_r;
  logic [255:0]         board_next_s;
  logic [3:0]           cursor_sq_s;
  logic [3:0]           source_sq_s;
  logic                 own_piece_s;

  // Reset synchroniser: asynchronous assertion, clocked release
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      rst_sync_r <= 2'b00;
    end else begin
      rst_sync_r <= {rst_sync_r[0], 1'b1};
    end
  end

  assign rst_n_s = rst_sync_r[1];

  assign raw_s = {BTN_CENTER, BTN_RIGHT, BTN_LEFT, BTN_DOWN, BTN_UP};

  for (genvar i = 0; i < BTN_COUNT; i++) begin : g_btn
    button_conditioner #(
      .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)
    ) u_cond (
      .clk   (clk),
      .rst_n (rst_n_s),
      .btn   (raw_s[i]),
      .level (btn_level_unused_s[i]),
      .press (press_s[i])
    );
  end

  // Single-action arbitration: CENTER > UP > DOWN > LEFT > RIGHT; nothing
  // acts during COMMIT and losing pulses are simply dropped
  always_comb begin
    act_center_s = 1'b0;
    act_up_s     = 1'b0;
    act_down_s   = 1'b0;
    act_left_s   = 1'b0;
    act_right_s  = 1'b0;
    if (state_r == ST_COMMIT) begin
      act_center_s = 1'b0;
    end else if (press_s[BTN_IDX_CENTER]) begin
      act_center_s = 1'b1;
    end else if (press_s[BTN_IDX_UP]) begin
      act_up_s = 1'b1;
    end else if (press_s[BTN_IDX_DOWN]) begin
      act_down_s = 1'b1;
    end else if (press_s[BTN_IDX_LEFT]) begin
      act_left_s = 1'b1;
    end else if (press_s[BTN_IDX_RIGHT]) begin
      act_right_s = 1'b1;
    end else begin
      act_center_s = 1'b0;
    end
  end

  assign cursor_addr_s = {cursor_row_r, cursor_col_r};
  assign cursor_sq_s   = board_r[{cursor_addr_s, 2'b00} +: 4];
  assign source_sq_s   = board_r[{select_addr_r, 2'b00} +: 4];
  assign own_piece_s   = (cursor_sq_s[2:0] != PIECE_NONE) && (cursor_sq_s[3] == turn_r);

  // Cursor registers: 3-bit wrap-around on the moved axis only
  always_ff @(posedge clk or negedge rst_n_s) begin
    if (!rst_n_s) begin
      cursor_row_r <= CURSOR_RESET[5:3];
      cursor_col_r <= CURSOR_RESET[2:0];
    end else if (act_up_s) begin
      cursor_row_r <= cursor_row_r - 3'd1;
    end else if (act_down_s) begin
      cursor_row_r <= cursor_row_r + 3'd1;
    end else if (act_left_s) begin
      cursor_col_r <= cursor_col_r - 3'd1;
    end else if (act_right_s) begin
      cursor_col_r <= cursor_col_r + 3'd1;
    end else begin
      cursor_row_r <= cursor_row_r;
      cursor_col_r <= cursor_col_r;
    end
  end

  // Select/move FSM next-state and control decode
  always_comb begin
    state_next_s     = state_r;
    select_en_next_s = select_en_r;
    select_load_s    = 1'b0;
    dest_load_s      = 1'b0;
    commit_s         = 1'b0;
    case (state_r)
      ST_IDLE: begin
        if (act_center_s && own_piece_s) begin
          select_load_s    = 1'b1;
          select_en_next_s = 1'b1;
          state_next_s     = ST_SELECTED;
        end else begin
          state_next_s     = ST_IDLE;
        end
      end
      ST_SELECTED: begin
        if (!act_center_s) begin
          state_next_s     = ST_SELECTED;
        end else if (cursor_addr_s == select_addr_r) begin
          select_en_next_s = 1'b0;
          state_next_s     = ST_IDLE;
        end else if (own_piece_s) begin
          select_load_s    = 1'b1;
        end else begin
          dest_load_s      = 1'b1;
          state_next_s     = ST_COMMIT;
        end
      end
      ST_COMMIT: begin
        commit_s         = 1'b1;
        select_en_next_s = 1'b0;
        state_next_s     = ST_IDLE;
      end
      default: begin
        select_en_next_s = 1'b0;
        state_next_s     = ST_IDLE;
      end
    endcase
  end

  // Board update on the COMMIT edge: source nibble moves, source cleared
  always_comb begin
    board_next_s = board_r;
    if (commit_s) begin
      board_next_s[{dest_r, 2'b00} +: 4]        = source_sq_s;
      board_next_s[{select_addr_r, 2'b00} +: 4] = 4'b0000;
    end else begin
      board_next_s = board_r;
    end
  end

  // FSM state, selection, destination, turn and board registers
  always_ff @(posedge clk or negedge rst_n_s) begin
    if (!rst_n_s) begin
      state_r       <= ST_IDLE;
      select_addr_r <= 6'd0;
      select_en_r   <= 1'b0;
      dest_r        <= 6'd0;
      turn_r        <= COLOR_WHITE;
      move_done_r   <= 1'b0;
      board_r       <= initial_board();
    end else begin
      state_r       <= state_next_s;
      select_en_r   <= select_en_next_s;
      move_done_r   <= commit_s;
      board_r       <= board_next_s;
      if (select_load_s) begin
        select_addr_r <= cursor_addr_s;
      end else begin
        select_addr_r <= select_addr_r;
      end
      if (dest_load_s) begin
        dest_r <= cursor_addr_s;
      end else begin
        dest_r <= dest_r;
      end
      if (commit_s) begin
        turn_r <= ~turn_r;
      end else begin
        turn_r <= turn_r;
      end
    end
  end

  assign BOARD       = board_r;
  assign CURSOR_ADDR = cursor_addr_s;
  assign SELECT_ADDR = select_addr_r;
  assign SELECT_EN   = select_en_r;
  assign TURN        = turn_r;
  assign MOVE_DONE   = move_done_r;

endmodule

// File: tb/tb_board_controller.sv
// ---------------------------------------------------------------------------
// tb_board_controller
// Scoreboard bench: each stimulus pushes the expected output snapshot and
// the cycle it must appear on; a negedge monitor pops and compares whenever
// any DUT output changes. DEBOUNCE_CYCLES = 4, so a press acts 8 cycles
// after the raw button rises and a move commits 9 cycles after it.
// ---------------------------------------------------------------------------
module tb_board_controller;

  localparam int DEB = 4;

  typedef struct {
    int           cyc;
    logic [255:0] board;
    logic [5:0]   cur;
    logic [5:0]   sel;
    logic         sel_en;
    logic         turn;
    logic         md;
  } exp_t;

  logic         clk;
  logic         rst;
  logic [4:0]   btn;  // 0 up, 1 down, 2 left, 3 right, 4 center
  logic [255:0] BOARD;
  logic [5:0]   CURSOR_ADDR;
  logic [5:0]   SELECT_ADDR;
  logic         SELECT_EN;
  logic         TURN;
  logic         MOVE_DONE;

  int           cyc;
  int           n_tests;
  int           n_fail;
  bit           mon_en;
  exp_t         q[$];

  logic [255:0] init_board;
  logic [255:0] m_board;
  logic [5:0]   m_cur;
  logic [5:0]   m_sel;
  logic         m_sel_en;
  logic         m_turn;
  logic         m_md;
  logic [270:0] prev_snap;

  board_controller #(.DEBOUNCE_CYCLES(DEB)) dut (
    .clk         (clk),
    .rst         (rst),
    .BTN_UP      (btn[0]),
    .BTN_DOWN    (btn[1]),
    .BTN_LEFT    (btn[2]),
    .BTN_RIGHT   (btn[3]),
    .BTN_CENTER  (btn[4]),
    .BOARD       (BOARD),
    .CURSOR_ADDR (CURSOR_ADDR),
    .SELECT_ADDR (SELECT_ADDR),
    .SELECT_EN   (SELECT_EN),
    .TURN        (TURN),
    .MOVE_DONE   (MOVE_DONE)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string name, input logic [255:0] act, input logic [255:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // Monitor: any output change must match the head of the scoreboard
  always @(negedge clk) begin
    logic [270:0] snap;
    exp_t e;
    snap = {BOARD, CURSOR_ADDR, SELECT_ADDR, SELECT_EN, TURN, MOVE_DONE};
    if (mon_en && (snap != prev_snap)) begin
      if (q.size() == 0) begin
        n_tests++;
        n_fail++;
        $display("FAIL unexpected_change: got cursor %0d sel %0d en %0b turn %0b md %0b, required no change (cycle %0d)",
                 CURSOR_ADDR, SELECT_ADDR, SELECT_EN, TURN, MOVE_DONE, cyc);
      end else begin
        e = q.pop_front();
        check("cycle",       256'(cyc),         256'(e.cyc));
        check("board",       BOARD,             e.board);
        check("cursor_addr", 256'(CURSOR_ADDR), 256'(e.cur));
        check("select_addr", 256'(SELECT_ADDR), 256'(e.sel));
        check("select_en",   256'(SELECT_EN),   256'(e.sel_en));
        check("turn",        256'(TURN),        256'(e.turn));
        check("move_done",   256'(MOVE_DONE),   256'(e.md));
      end
    end
    prev_snap = snap;
  end

  task automatic push(input int at);
    exp_t e;
    e.cyc = at; e.board = m_board; e.cur = m_cur; e.sel = m_sel;
    e.sel_en = m_sel_en; e.turn = m_turn; e.md = m_md;
    q.push_back(e);
  endtask

  // Press one button; if an output change is expected it lands 8 cycles later
  task automatic press(input int b, input int hold, input bit expect_change);
    @(posedge clk); #1;
    if (expect_change) push(cyc + DEB + 4);
    btn[b] = 1'b1;
    repeat (hold) @(posedge clk);
    #1 btn[b] = 1'b0;
    repeat (14) @(posedge clk);
  endtask

  // Cursor step with a hand-computed destination address
  task automatic step(input int b, input logic [5:0] new_cur);
    m_cur = new_cur;
    press(b, 10, 1'b1);
  endtask

  task automatic model_reset();
    m_board = init_board; m_cur = 6'd60; m_sel = 6'd0;
    m_sel_en = 1'b0; m_turn = 1'b0; m_md = 1'b0;
  endtask

  task automatic check_reset(input string tag);
    check({tag, "_sq0"},   256'(BOARD[3:0]),     256'(4'b1100));
    check({tag, "_sq56"},  256'(BOARD[227:224]), 256'(4'b0100));
    check({tag, "_sq60"},  256'(BOARD[243:240]), 256'(4'b0110));
    check({tag, "_board"}, BOARD,                init_board);
    check({tag, "_cursor"}, 256'(CURSOR_ADDR),   256'(6'd60));
    check({tag, "_sel"},    256'(SELECT_ADDR),   256'(6'd0));
    check({tag, "_sel_en"}, 256'(SELECT_EN),     256'(1'b0));
    check({tag, "_turn"},   256'(TURN),          256'(1'b0));
    check({tag, "_md"},     256'(MOVE_DONE),     256'(1'b0));
  endtask

  initial begin
    int br[8];
    br = '{4, 2, 3, 5, 6, 3, 2, 4};
    init_board = 256'd0;
    for (int c = 0; c < 8; c++) begin
      init_board[c*4 +: 4]        = 4'(8 + br[c]);
      init_board[(8 + c)*4 +: 4]  = 4'b1001;
      init_board[(48 + c)*4 +: 4] = 4'b0001;
      init_board[(56 + c)*4 +: 4] = 4'(br[c]);
    end
    n_tests = 0; n_fail = 0; mon_en = 1'b0;
    btn = 5'b00000;
    rst = 1'b0;
    model_reset();
    repeat (3) @(posedge clk);
    #1 check_reset("reset");
    rst = 1'b1;
    repeat (4) @(posedge clk);
    #1 check_reset("reset_release");
    mon_en = 1'b1;

    // UP held 20 cycles: 60 -> 52 exactly 8 cycles after assertion
    m_cur = 6'd52;
    press(0, 20, 1'b1);
    // 3-cycle glitch on UP: no change
    @(posedge clk); #1 btn[0] = 1'b1;
    repeat (3) @(posedge clk);
    #1 btn[0] = 1'b0;
    repeat (14) @(posedge clk);

    // Walk to row 1, col 0 and try to select a black pawn on white's turn
    step(0, 6'd44); step(0, 6'd36); step(0, 6'd28); step(0, 6'd20); step(0, 6'd12);
    step(2, 6'd11); step(2, 6'd10); step(2, 6'd9);  step(2, 6'd8);
    press(4, 10, 1'b0);
    step(3, 6'd9);  step(3, 6'd10); step(3, 6'd11); step(3, 6'd12);
    // Row wrap: 4 -> 60, column wrap: 63 -> 56
    step(0, 6'd4);  step(0, 6'd60);
    step(3, 6'd61); step(3, 6'd62); step(3, 6'd63); step(3, 6'd56);
    step(3, 6'd57); step(3, 6'd58); step(3, 6'd59); step(3, 6'd60);
    step(0, 6'd52);

    // Select 52, reselect own piece 53, then deselect on 53
    m_sel = 6'd52; m_sel_en = 1'b1; press(4, 10, 1'b1);
    step(3, 6'd53);
    m_sel = 6'd53; press(4, 10, 1'b1);
    m_sel_en = 1'b0; press(4, 10, 1'b1);

    // White move 52 -> 36: commit edge at +9, MOVE_DONE falls at +10
    step(2, 6'd52);
    m_sel = 6'd52; m_sel_en = 1'b1; press(4, 10, 1'b1);
    step(0, 6'd44); step(0, 6'd36);
    @(posedge clk); #1;
    m_board[36*4 +: 4] = 4'b0001;
    m_board[52*4 +: 4] = 4'b0000;
    m_turn = 1'b1; m_sel_en = 1'b0; m_md = 1'b1;
    push(cyc + DEB + 5);
    m_md = 1'b0;
    push(cyc + DEB + 6);
    btn[4] = 1'b1;
    repeat (10) @(posedge clk);
    #1 btn[4] = 1'b0;
    repeat (14) @(posedge clk);
    #1;
    check("move_dest",   256'(BOARD[147:144]), 256'(4'b0001));
    check("move_source", 256'(BOARD[211:208]), 256'(4'b0000));
    check("move_turn",   256'(TURN),           256'(1'b1));

    // Black to move: CENTER and UP together on the black pawn at 12
    step(0, 6'd28); step(0, 6'd20); step(0, 6'd12);
    @(posedge clk); #1;
    m_sel = 6'd12; m_sel_en = 1'b1;
    push(cyc + DEB + 4);
    btn[4] = 1'b1; btn[0] = 1'b1;
    repeat (10) @(posedge clk);
    #1 btn = 5'b00000;
    repeat (14) @(posedge clk);

    #1 check("scoreboard_drained", 256'(q.size()), 256'(0));

    // Reset while SELECTED restores everything, including the board
    mon_en = 1'b0;
    @(posedge clk); #3 rst = 1'b0;
    #1 check_reset("mid_reset");
    repeat (3) @(posedge clk);
    #1 rst = 1'b1;
    repeat (4) @(posedge clk);
    #1 check_reset("mid_reset_release");

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
